// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared FSM state type and default parameters for the ADC SPI read path.
package adc_spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, CLK_HI, CLK_LO, HOLD, DONE} state_t;
    localparam int DEF_CLK_DIV       = 4;
    localparam int DEF_N_BITS        = 12;
    localparam int DEF_LEAD_BITS     = 4;
    localparam int DEF_SAMPLE_PERIOD = 1000;
endpackage

// File: rtl/adc_spi_ctrl_if.sv
// adc_spi_ctrl_if: request, shift-register and SPI pin bundle between the sequencer and its neighbours.
interface adc_spi_ctrl_if #(
    parameter int N_BITS = adc_spi_pkg::DEF_N_BITS
);
    logic              start;
    logic              auto_en;
    logic [N_BITS-1:0] sr_data;
    logic              sclk;
    logic              cs_n;
    logic              shift_en;
    logic [N_BITS-1:0] sample;
    logic              sample_valid;
    logic              busy;
    modport master (
        input  start, auto_en, sr_data,
        output sclk, cs_n, shift_en, sample, sample_valid, busy
    );
    modport slave (
        output start, auto_en, sr_data,
        input  sclk, cs_n, shift_en, sample, sample_valid, busy
    );
endinterface

// File: rtl/adc_period_timer.sv
// adc_period_timer: auto-mode period counter and single-bit pending request.
module adc_period_timer import adc_spi_pkg::*; #(
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic i_auto_en,
    input  logic i_clr,
    output logic o_pending
);
    localparam int CW = $clog2(SAMPLE_PERIOD);
    logic [CW-1:0] r_cnt;
    logic          r_pending;
    logic          w_expire;
    assign w_expire  = i_auto_en && r_cnt == CW'(SAMPLE_PERIOD - 1);
    assign o_pending = r_pending;
    // a frame launch that coincides with an expiry consumes it, so one frame only
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_cnt     <= (!i_auto_en || w_expire) ? '0 : r_cnt + 1'b1;
            r_pending <= !i_auto_en ? 1'b0 : i_clr ? 1'b0 : w_expire ? 1'b1 : r_pending;
        end
endmodule

// File: rtl/adc_spi_ctrl.sv
// adc_spi_ctrl: SPI-master sequencer generating cs_n/sclk, shift strobes and the latched ADC sample.
module adc_spi_ctrl import adc_spi_pkg::*; #(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int N_BITS        = DEF_N_BITS,
    parameter int LEAD_BITS     = DEF_LEAD_BITS,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
    input logic           clk,
    input logic           reset,
    adc_spi_ctrl_if.master bus
);
    localparam int FRAME = LEAD_BITS + N_BITS;
    localparam int PW    = $clog2(CLK_DIV);
    localparam int BW    = $clog2(FRAME);
    state_t            r_state, w_ns;
    logic [PW-1:0]     r_phase, w_phase;
    logic [BW-1:0]     r_bit, w_bit;
    logic              w_pending, w_clr, w_phase_end;
    logic              r_sclk, r_cs_n, r_shift_en, r_sample_valid, r_busy;
    logic [N_BITS-1:0] r_sample;
    adc_period_timer #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_auto_en (bus.auto_en),
        .i_clr     (w_clr),
        .o_pending (w_pending)
    );
    always_comb begin
        w_ns        = r_state;
        w_phase     = r_phase;
        w_bit       = r_bit;
        w_phase_end = r_phase == PW'(CLK_DIV - 1);
        w_clr       = r_state == IDLE && (bus.start || w_pending);
        case (r_state)
            IDLE: if (w_clr) begin
                w_ns    = SETUP;
                w_phase = '0;
                w_bit   = '0;
            end
            SETUP: begin
                w_phase = w_phase_end ? '0 : r_phase + 1'b1;
                if (w_phase_end) w_ns = CLK_HI;
            end
            CLK_HI: begin
                w_phase = w_phase_end ? '0 : r_phase + 1'b1;
                if (w_phase_end) w_ns = CLK_LO;
            end
            CLK_LO: begin
                w_phase = w_phase_end ? '0 : r_phase + 1'b1;
                if (w_phase_end && r_bit == BW'(FRAME - 1)) w_ns = HOLD;
                else if (w_phase_end) begin
                    w_ns  = CLK_HI;
                    w_bit = r_bit + 1'b1;
                end
            end
            HOLD:    w_ns = DONE;
            default: w_ns = IDLE;
        endcase
    end
    // outputs are decoded from the next state so every pin comes straight from a flop
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state        <= IDLE;
            r_phase        <= '0;
            r_bit          <= '0;
            r_sclk         <= 1'b0;
            r_cs_n         <= 1'b1;
            r_shift_en     <= 1'b0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_sample       <= '0;
        end else begin
            r_state        <= w_ns;
            r_phase        <= w_phase;
            r_bit          <= w_bit;
            r_sclk         <= w_ns == CLK_HI;
            r_cs_n         <= w_ns == IDLE || w_ns == DONE;
            r_shift_en     <= w_ns == CLK_HI && w_phase == PW'(CLK_DIV - 1) && w_bit >= BW'(LEAD_BITS);
            r_sample_valid <= w_ns == DONE;
            r_busy         <= w_ns != IDLE;
            if (w_ns == DONE) r_sample <= bus.sr_data;
        end
    assign bus.sclk         = r_sclk;
    assign bus.cs_n         = r_cs_n;
    assign bus.shift_en     = r_shift_en;
    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_sample_valid;
    assign bus.busy         = r_busy;
endmodule
